fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer that produces the 16-bit `instruction` word consumed by `Control_unit`, closing the loop on that block's `pc_jump` / `RAM_adr` redirect outputs. It owns the program counter and issues single-word reads to instruction memory. It buffers up to two fetched words: an output register plus a one-entry prefetch. It presents words to the decoder with a valid/ready handshake and flushes the stream when a jump or taken branch is reported at accept.

## Interface
Clocking: one clock; reset is synchronous and active-high. Clock port `clk`, reset port `rst`.

Parameters:
- `PC_W`, 8, program-counter / instruction-address width.
- `INSTR_W`, 16, instruction width.
- `RESET_PC`, 0, first fetch address after reset.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `imem_req`  out  1  read request, one cycle per request.
- `imem_addr`  out  PC_W  word address of the request; valid when `imem_req`=1.
- `imem_rvalid`  in  1  read data valid; exactly one per request, ≥1 cycle after it.
- `imem_rdata`  in  INSTR_W  read data.
- `instruction`  out  INSTR_W  word presented to the decoder.
- `instr_valid`  out  1  `instruction` is valid.
- `instr_ready`  in  1  decoder accepts `instruction`.
- `instr_pc`  out  PC_W  address of the presented word.
- `pc_jump`  in  1  jump redirect; sampled only on accept.
- `branch_taken`  in  1  branch redirect; sampled only on accept.
- `target_adr`  in  PC_W  redirect target.
- `halt`  in  1  stop issuing new requests while high.

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - Output slot: `instruction`, `instr_pc`, `instr_valid`.
  - Prefetch slot: data, pc, valid.
  - `outstanding`: one bit.
  - `drop`: one bit.
- Two-state FSM, `RUN` / `HALTED`:
  - `halt`=1 moves RUN→HALTED.
  - `halt`=0 moves HALTED→RUN.
  - An outstanding response still completes normally while HALTED.
- Issue:
  - Condition: `imem_req` = RUN & !`outstanding` & (!`instr_valid` | !prefetch valid).
  - Function: combinational from registered state and `halt`, forced 0 during `rst`.
  - `imem_addr` = `fetch_pc`.
  - On issue: `outstanding`←1 and `fetch_pc`←`fetch_pc`+1, modulo 2^PC_W (0xFF wraps to 0x00).
- Response (`imem_rvalid`):
  - `outstanding`←0.
  - If `drop`=1, discard the data and clear `drop`.
  - Otherwise write the output slot if it is empty or being accepted this cycle with an empty prefetch slot; else write the prefetch slot.
- Accept = `instr_valid` & `instr_ready`:
  - No redirect: the prefetch slot moves into the output slot, or the output slot empties.
  - Redirect (`pc_jump` | `branch_taken`):
    - Both slots are invalidated.
    - `fetch_pc`←`target_adr`.
    - An outstanding request not returning this cycle sets `drop`.
    - A response arriving this same cycle is discarded.
- `instr_pc` always carries the address the word was fetched from.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `instruction`=0, `instr_valid`=0, `instr_pc`=0.
  - `fetch_pc`=RESET_PC; prefetch, `outstanding` and `drop` cleared; state RUN.
- First cycle after `rst` falls: `imem_req`=1, `imem_addr`=RESET_PC.
- Latency: the response at cycle n gives `instr_valid`=1 at n+1.
  - With one-cycle memory, request-to-valid is 2 cycles.
  - Steady-state throughput is one word per 2 cycles, since only one request is outstanding.
- After a redirect on accept at cycle n:
  - `imem_req`=1 to `target_adr` at n+1 if nothing is outstanding.
  - Otherwise the request follows the cycle after the dropped response.
- `instruction` / `instr_pc` hold stable while `instr_valid`=1 and `instr_ready`=0.
- `rst` mid-operation returns all registers to reset values on the next edge. A response arriving after reset for a pre-reset request is a memory-side violation and is not handled.

## Structure
- Shared package `cpu_pkg`:
  - `PC_W`, `INSTR_W`.
  - Opcode constants (ADD 0000, SUB 0010, LOAD 0100, JUMP 1000, branches 1101/1110/1111), shared with `Control_unit`.
  - `fetch_state_t` {RUN, HALTED}.
- One natural sub-module, `fetch_buf2`: the two-entry output/prefetch skid buffer with a flush input. Issue logic, PC, drop and FSM stay in `fetch_unit`.

## Test plan
- Reset release, 1-cycle memory returning 0x0123 at addr 0, `instr_ready`=1:
  - `imem_req` at addr 0x00 on the first cycle.
  - `instruction`=0x0123, `instr_pc`=0x00 two cycles later.
- Sequential stream with `instr_ready`=0 for 6 cycles:
  - Exactly two requests (0x00, 0x01) issue, then `imem_req` stays 0.
  - On ready, words are delivered in order with `instr_pc` 0x00, 0x01.
- Redirect drop:
  - Accept a word with `pc_jump`=1, `target_adr`=0x40 while the request for 0x03 is outstanding.
  - Its response is discarded.
  - The next presented word has `instr_pc`=0x40.
- Wrap-around: RESET_PC=0xFE, free-running → `instr_pc` sequence 0xFE, 0xFF, 0x00.
- `halt` asserted with one request outstanding:
  - The response is delivered and no new `imem_req` issues.
  - Deasserting `halt` resumes at the next address.
- `rst` asserted for 1 cycle mid-stream with both slots full:
  - Next cycle `instr_valid`=0.
  - The first cycle after `rst` falls issues `imem_req` to RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcodes decoded by Control_unit,
// and the fetch sequencer state type.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_LOAD = 4'b0100;
  localparam logic [3:0] OP_JUMP = 4'b1000;
  localparam logic [3:0] OP_BR0  = 4'b1101;
  localparam logic [3:0] OP_BR1  = 4'b1110;
  localparam logic [3:0] OP_BR2  = 4'b1111;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry skid buffer between instruction memory and the decoder:
// an output slot presented downstream plus a one-word prefetch slot.
module fetch_buf2 #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [PC_W-1:0]    wr_pc,
  input  logic               rd_en,
  output logic [INSTR_W-1:0] out_data,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_valid,
  output logic               has_room
);
  import cpu_pkg::*;

  logic [INSTR_W-1:0] pf_data;
  logic [PC_W-1:0]    pf_pc;
  logic               pf_valid;
  logic               out_free;

  // A write lands in the output slot only when that keeps program order.
  assign out_free = ~out_valid | (rd_en & ~pf_valid);
  assign has_room = ~(out_valid & pf_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_pc    <= '0;
      pf_valid  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      pf_valid  <= 1'b0;
    end else begin
      if (wr_en && out_free) begin
        out_data  <= wr_data;
        out_pc    <= wr_pc;
        out_valid <= 1'b1;
      end else if (rd_en && pf_valid) begin
        out_data  <= pf_data;
        out_pc    <= pf_pc;
        out_valid <= 1'b1;
      end else if (rd_en) begin
        out_valid <= 1'b0;
      end

      if (wr_en && !out_free) begin
        pf_data  <= wr_data;
        pf_pc    <= wr_pc;
        pf_valid <= 1'b1;
      end else if (rd_en && pf_valid) begin
        pf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding read at a
// time, and flushes the buffered stream on a jump or taken branch at accept.
module fetch_unit #(
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter int              INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               pc_jump,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    target_adr,
  input  logic               halt
);
  import cpu_pkg::*;

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] req_pc;
  logic            outstanding;
  logic            drop;
  logic            accept;
  logic            flush;
  logic            rsp_wr;
  logic            buf_room;

  assign accept    = instr_valid & instr_ready;
  assign flush     = accept & (pc_jump | branch_taken);
  assign rsp_wr    = imem_rvalid & ~drop & ~flush;
  assign imem_req  = ~rst & (state == RUN) & ~halt & ~outstanding & buf_room;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:    if (halt)  state_nxt = HALTED;
      HALTED: if (!halt) state_nxt = RUN;
    endcase
  end

  // A request issued in the same cycle as a redirect targets the stale PC,
  // so it is dropped exactly like one already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (flush)         fetch_pc <= target_adr;
      else if (imem_req) fetch_pc <= fetch_pc + 1'b1;

      if (imem_req)         outstanding <= 1'b1;
      else if (imem_rvalid) outstanding <= 1'b0;

      if (flush && ((outstanding && !imem_rvalid) || imem_req)) drop <= 1'b1;
      else if (imem_rvalid)                                      drop <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req) req_pc <= fetch_pc;
  end

  fetch_buf2 #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_en     (rsp_wr),
    .wr_data   (imem_rdata),
    .wr_pc     (req_pc),
    .rd_en     (accept),
    .out_data  (instruction),
    .out_pc    (instr_pc),
    .out_valid (instr_valid),
    .has_room  (buf_room)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder with random latency and an
// architectural model of the delivered (pc, instruction) stream.
module tb_fetch_unit;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               imem_req, imem_rvalid;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid, instr_ready;
  logic [PC_W-1:0]    instr_pc, target_adr;
  logic               pc_jump, branch_taken, halt;

  logic               w_req, w_rvalid, w_valid;
  logic [PC_W-1:0]    w_addr, w_pc;
  logic [INSTR_W-1:0] w_rdata, w_instr;

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instruction(instruction),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_pc(instr_pc),
    .pc_jump(pc_jump), .branch_taken(branch_taken), .target_adr(target_adr), .halt(halt)
  );

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(8'hFE)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .instruction(w_instr),
    .instr_valid(w_valid), .instr_ready(1'b1), .instr_pc(w_pc),
    .pc_jump(1'b0), .branch_taken(1'b0), .target_adr(8'h00), .halt(1'b0)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, n_acc = 0;
  logic [PC_W-1:0] pend_addr[$];
  int              pend_due[$];
  int              pend_before;
  int              lat_min = 1, lat_max = 1;
  int              rdy_mode = 0;
  bit              ready_k = 1'b0, halt_k = 1'b0, rst_k = 1'b1;
  int              redir_pct = 0, redir_pc = -1;
  logic [PC_W-1:0] redir_tgt = '0;
  logic            s_req, s_valid;
  logic [PC_W-1:0] s_addr, s_pc;
  logic [INSTR_W-1:0] s_instr;
  bit              s_acc, s_redir;
  logic [PC_W-1:0] exp_pc = '0, last_acc_pc = '0;
  bit              hold_arm = 1'b0;
  logic [INSTR_W-1:0] hold_instr;
  logic [PC_W-1:0] hold_pc;
  int              drop_due = -1;
  logic            w_req_q = 1'b0;
  logic [PC_W-1:0] w_addr_q = '0;
  logic [PC_W-1:0] w_seen[$];

  function automatic logic [INSTR_W-1:0] memf(input logic [PC_W-1:0] a);
    return 16'h0123 + {a, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit rdy, jmp, br;
    logic [PC_W-1:0] tgt;
    @(negedge clk);
    cyc++;
    rst  = rst_k;
    halt = halt_k;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
    w_rvalid = w_req_q;
    w_rdata  = memf(w_addr_q);
    pend_before = pend_due.size();
    #1;
    s_req = imem_req; s_addr = imem_addr;
    s_valid = instr_valid; s_pc = instr_pc; s_instr = instruction;
    w_req_q = w_req; w_addr_q = w_addr;
    s_acc = 1'b0; s_redir = 1'b0;
    if (!rst_k && w_valid === 1'b1 && w_seen.size() < 3) begin
      w_seen.push_back(w_pc);
      chk("wrap_instr", 32'(w_instr), 32'(memf(w_pc)));
    end
    if (rst_k) begin
      chk("req_in_rst", 32'(s_req), 32'h0);
      pc_jump = 1'b0; branch_taken = 1'b0; instr_ready = 1'b0; hold_arm = 1'b0;
      return;
    end
    if (s_req) begin
      chk("one_outstanding", 32'(pend_before + int'(imem_rvalid)), 32'h0);
      pend_addr.push_back(s_addr);
      pend_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
    end
    if (halt_k) chk("halt_no_req", 32'(s_req), 32'h0);
    if (hold_arm) begin
      chk("hold_valid", 32'(s_valid), 32'h1);
      chk("hold_instr", 32'(s_instr), 32'(hold_instr));
      chk("hold_pc", 32'(s_pc), 32'(hold_pc));
    end
    case (rdy_mode)
      0:       rdy = ready_k;
      1:       rdy = ($urandom_range(0, 99) < 60);
      default: rdy = (pend_before > 0);
    endcase
    s_acc = s_valid && rdy;
    jmp = 1'b0; br = 1'b0; tgt = PC_W'($urandom);
    if (s_acc) begin
      chk("acc_pc", 32'(s_pc), 32'(exp_pc));
      chk("acc_instr", 32'(s_instr), 32'(memf(exp_pc)));
      n_acc++;
      last_acc_pc = s_pc;
      if (redir_pc >= 0) s_redir = (int'(s_pc) == redir_pc);
      else               s_redir = ($urandom_range(0, 99) < redir_pct);
      if (s_redir) begin
        if (redir_pc >= 0) begin tgt = redir_tgt; jmp = 1'b1; end
        else if ($urandom_range(0, 1) == 1) jmp = 1'b1;
        else br = 1'b1;
        drop_due = (pend_due.size() > 0) ? pend_due[0] : -1;
        exp_pc = tgt;
      end else begin
        exp_pc = s_pc + 8'd1;
      end
    end else if (redir_pct > 0) begin
      jmp = 1'($urandom_range(0, 1));
      br  = 1'($urandom_range(0, 1));
    end
    pc_jump = jmp; branch_taken = br; target_adr = tgt; instr_ready = rdy;
    hold_arm = s_valid && !rdy; hold_instr = s_instr; hold_pc = s_pc;
  endtask

  task automatic do_reset(input int n);
    pend_addr.delete(); pend_due.delete();
    rst_k = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    rst_k = 1'b0;
    exp_pc = 8'h00; hold_arm = 1'b0; drop_due = -1;
  endtask

  initial begin
    logic [PC_W-1:0] wexp[3];
    logic [PC_W-1:0] rq[$];
    logic [PC_W-1:0] got_pc[$];
    bit found;
    int acc0;
    rst = 1'b1; halt = 1'b0; instr_ready = 1'b0; pc_jump = 1'b0; branch_taken = 1'b0;
    target_adr = '0; imem_rvalid = 1'b0; imem_rdata = '0; w_rvalid = 1'b0; w_rdata = '0;
    wexp[0] = 8'hFE; wexp[1] = 8'hFF; wexp[2] = 8'h00;

    // Reset release with 1-cycle memory and a ready decoder
    do_reset(2);
    rdy_mode = 0; ready_k = 1'b1; lat_min = 1; lat_max = 1;
    cycle();
    chk("rst_valid", 32'(s_valid), 32'h0);
    chk("rst_instr", 32'(s_instr), 32'h0);
    chk("rst_pc", 32'(s_pc), 32'h0);
    chk("first_req", 32'(s_req), 32'h1);
    chk("first_addr", 32'(s_addr), 32'h0);
    cycle();
    cycle();
    chk("t1_valid", 32'(s_valid), 32'h1);
    chk("t1_instr", 32'(s_instr), 32'h0123);
    chk("t1_pc", 32'(s_pc), 32'h0);
    for (int i = 0; i < 10; i++) cycle();
    chk("wrap_count", 32'(w_seen.size()), 32'h3);
    for (int k = 0; k < w_seen.size(); k++) chk("wrap_pc", 32'(w_seen[k]), 32'(wexp[k]));

    // Decoder stalled: two requests fill both slots, then issue stops
    do_reset(2);
    ready_k = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_req) rq.push_back(s_addr);
    end
    chk("stall_req_count", 32'(rq.size()), 32'h2);
    for (int k = 0; k < rq.size(); k++) chk("stall_req_addr", 32'(rq[k]), 32'(k));
    ready_k = 1'b1;
    for (int i = 0; i < 10 && got_pc.size() < 2; i++) begin
      cycle();
      if (s_acc) got_pc.push_back(s_pc);
    end
    chk("stall_deliver_count", 32'(got_pc.size()), 32'h2);
    for (int k = 0; k < got_pc.size(); k++) chk("stall_deliver_pc", 32'(got_pc[k]), 32'(k));

    // Redirect while the request for 0x03 is outstanding
    do_reset(2);
    rdy_mode = 2; lat_min = 4; lat_max = 4; redir_pc = 2; redir_tgt = 8'h40;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      cycle();
      if (s_redir) found = 1'b1;
    end
    chk("redir_seen", 32'(found), 32'h1);
    chk("redir_while_outstanding", 32'(drop_due > cyc), 32'h1);
    redir_pc = -1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (s_req) found = 1'b1;
    end
    chk("redir_req_seen", 32'(found), 32'h1);
    chk("redir_req_addr", 32'(s_addr), 32'h40);
    chk("redir_req_cycle", 32'(cyc), 32'(drop_due + 1));
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (s_acc) found = 1'b1;
    end
    chk("redir_next_seen", 32'(found), 32'h1);
    chk("redir_next_pc", 32'(last_acc_pc), 32'h40);

    // Halt with one request outstanding
    do_reset(2);
    rdy_mode = 0; ready_k = 1'b1; lat_min = 3; lat_max = 3;
    cycle();
    chk("halt_first_req", 32'(s_req), 32'h1);
    halt_k = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_acc) found = 1'b1;
    end
    chk("halt_delivered", 32'(found), 32'h1);
    chk("halt_delivered_pc", 32'(last_acc_pc), 32'h0);
    halt_k = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_req) found = 1'b1;
    end
    chk("resume_seen", 32'(found), 32'h1);
    chk("resume_addr", 32'(s_addr), 32'h1);

    // Mid-stream reset with both slots full
    do_reset(2);
    ready_k = 1'b0; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) cycle();
    chk("full_before_rst", 32'(s_valid), 32'h1);
    do_reset(1);
    cycle();
    chk("midrst_valid", 32'(s_valid), 32'h0);
    chk("midrst_req", 32'(s_req), 32'h1);
    chk("midrst_addr", 32'(s_addr), 32'h0);

    // Randomized traffic against the stream model
    do_reset(2);
    rdy_mode = 1; lat_min = 1; lat_max = 4; redir_pct = 20; redir_pc = -1;
    acc0 = n_acc;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) halt_k = !halt_k;
      cycle();
    end
    halt_k = 1'b0;
    chk("rand_progress", 32'((n_acc - acc0) > 200), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
